reg_viewer: RTL and testbench
=============================

# reg_viewer

Register-file viewer that consumes the hart's `reg_state` and drives the board's six active-low 7-segment displays. It shows one selected architectural register (`xregs[sel]`) at a time. The block owns a snapshot register, an auto-paging state machine that alternates between the low 24 bits and the index plus high 8 bits, and a stretched "value changed" indicator. It sits in the FPGA top level directly downstream of the hart.

## Interface
Parameters:
- `PAGE_CYCLES`, default 50_000_000: cycles per display page (1 s at 50 MHz); legal range ≥ 2.
- `STRETCH_CYCLES`, default 5_000_000: length of the `changed` pulse in cycles; legal range ≥ 1.

Ports:
- `clk` in 1: single clock (CLOCK_50 at top level).
- `reset` in 1: asynchronous, active-high reset.
- `reg_state` in `reg_state_t`: live hart register state; only `xregs[0..31][31:0]` are used.
- `sel` in 5: index of the register to display.
- `freeze` in 1: 1 holds the current snapshot.
- `hex0`..`hex5` out 7 each: active-low segments {g,f,e,d,c,b,a}; `hex0` is the rightmost display.
- `changed` out 1: high while a value change is being stretched.
- `page` out 1: 0 = PAGE_LO, 1 = PAGE_HI.

## Operation
- **Snapshot.** When `freeze`=0, each edge loads `snap <= reg_state.xregs[sel]` and `snap_idx <= sel`. When `freeze`=1, `snap` and `snap_idx` hold and `sel` changes are ignored.
- **Select change.** Condition: `freeze`=0 and `sel != snap_idx`. Response: page ← PAGE_LO and timer ← 0. No `changed` pulse.
- **Value change.** Condition: `freeze`=0, `sel == snap_idx`, and `xregs[sel] != snap`. Response: stretch counter ← STRETCH_CYCLES. Retriggers while already active. `changed` = (stretch counter != 0); the counter decrements to 0.
- **Page FSM.** States are PAGE_LO and PAGE_HI. The timer counts 0..PAGE_CYCLES-1. At the terminal count, the state toggles and the timer returns to 0. Timer width is `$clog2(PAGE_CYCLES)`. `freeze` does not stop paging.
- **Simultaneous events.** A select change beats a timer terminal count in the same cycle (result: PAGE_LO, timer 0).
- **PAGE_LO display.** `hex5..hex0` = `snap[23:20]`..`snap[3:0]`.
- **PAGE_HI display.**
  - `hex5`,`hex4` = `{3'b0,snap_idx[4]}`, `snap_idx[3:0]`, i.e. 00..1F.
  - `hex3`,`hex2` = blank (7'b1111111).
  - `hex1`,`hex0` = `snap[31:28]`, `snap[27:24]`.
- **Digit encoding.**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **x0.** No special case; the displayed value is whatever the hart reports.

## Timing
- **Reset values (applied asynchronously, without a clock edge):**
  - `hex0..hex5` = 7'b1111111 (blank).
  - `changed`=0, `page`=0.
  - `snap`=0, `snap_idx`=0, timer=0, stretch=0.
- **Latency.** All outputs are registered.
  - `reg_state`/`sel` to `snap`: 1 cycle.
  - `snap`/page to `hex*`: 1 cycle.
  - Total input to display: 2 cycles.
  - Page toggle to new display: 1 cycle.
  - Value change to `changed`=1: 1 cycle. `changed` stays high exactly STRETCH_CYCLES cycles after the last trigger.
- **After reset release.** The first edge samples; the second edge drives valid digits.
- **Freeze release.**
  - If `sel == snap_idx` and the value differs: `changed` pulses.
  - If `sel` differs: treated as a select change.
- **Reset mid-operation.** All state returns to reset values immediately. Paging restarts at PAGE_LO with timer 0.

## Structure
- `reg_state_t` comes from the existing hart package; this block does not redefine it.
- A shared display package holds:
  - segment constants `SEG_BLANK` and `SEG_DIGIT[16]`;
  - the `page_t` enum (PAGE_LO, PAGE_HI).
- Sub-module `seg7_hex` is a combinational 4-bit to 7-segment active-low decoder, instantiated six times.
- The top level maps LEDR/HEX/SW to this block.

## Test plan
Parameters: PAGE_CYCLES=8, STRETCH_CYCLES=4.

1. **Reset then first display.** Assert `reset` with no clock: all `hex`=1111111, `changed`=0, `page`=0. Release with `xregs[10]`=32'h12ABCDEF and `sel`=10. Two edges later, `hex5..hex0` = A,b,C,d,E,F (0001000, 0000011, 1000110, 0100001, 0000110, 0001110).
2. **Paging.** After 8 cycles, `page`=1 and `hex5/4` = 0,A; `hex3/2` blank; `hex1/0` = 1,2 (1111001, 0100100). After 8 more cycles, `page`=0 and PAGE_LO digits are shown again.
3. **Change stretch.** `xregs[10]` → 32'h12ABCDF0: `changed` goes high next cycle for 4 cycles. A second change 2 cycles in extends `changed` to 4 cycles past the retrigger.
4. **Select change during PAGE_HI.** `sel` 10→31: `page`=0 next cycle, timer restarts, `hex5/4` later show 1,F on PAGE_HI, and `changed` stays 0.
5. **Freeze.** Set `freeze`=1 and change `xregs[10]`: display and `changed` are unaffected. Drop `freeze`: `changed` pulses 4 cycles and the new value appears 2 cycles later.
6. **Reset mid-operation.** Assert `reset` in PAGE_HI with `changed`=1: outputs go blank/0 immediately. After release, paging restarts at PAGE_LO with a full 8-cycle page.

Source files
------------

// File: rtl/hart_pkg.sv
// Hart register-state type consumed by downstream debug/visualisation blocks.
package hart_pkg;

  typedef struct packed {
    logic [31:0][31:0] xregs;
  } reg_state_t;

endpackage

// File: rtl/reg_viewer_pkg.sv
// Shared 7-segment display constants and the page enum for the register viewer.
package reg_viewer_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    PAGE_LO = 1'b0,
    PAGE_HI = 1'b1
  } page_t;

endpackage

// File: rtl/reg_viewer_if.sv
// Bundle between the hart-side top level and the register viewer.
interface reg_viewer_if;
  import hart_pkg::*;

  reg_state_t reg_state;
  logic [4:0] sel;
  logic       freeze;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic [6:0] hex4;
  logic [6:0] hex5;
  logic       changed;
  logic       page;

  modport master (
    output reg_state, sel, freeze,
    input  hex0, hex1, hex2, hex3, hex4, hex5, changed, page
  );

  modport slave (
    input  reg_state, sel, freeze,
    output hex0, hex1, hex2, hex3, hex4, hex5, changed, page
  );

endinterface

// File: rtl/reg_viewer_seg7_hex.sv
// Combinational 4-bit to active-low 7-segment decoder.
module seg7_hex
  import reg_viewer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_DIGIT[nibble];

endmodule

// File: rtl/reg_viewer.sv
// Register-file viewer: snapshots xregs[sel], pages it across six 7-segment
// displays and stretches a "value changed" indicator.
module reg_viewer
  import reg_viewer_pkg::*;
#(
  parameter int PAGE_CYCLES    = 50_000_000,
  parameter int STRETCH_CYCLES = 5_000_000
) (
  input logic         clk,
  input logic         reset,
  reg_viewer_if.slave bus
);

  localparam int TIMER_W   = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [TIMER_W-1:0]   TIMER_LAST   = TIMER_W'(PAGE_CYCLES - 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);

  logic [31:0]          snap_q, snap_d;
  logic [4:0]           snap_idx_q, snap_idx_d;
  page_t                page_q, page_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [STRETCH_W-1:0] stretch_q, stretch_d;
  logic                 changed_q, changed_d;
  logic [6:0]           hex_q [NUM_DIGITS];
  logic [6:0]           hex_d [NUM_DIGITS];
  logic [3:0]           nibble [NUM_DIGITS];
  logic [6:0]           seg [NUM_DIGITS];

  logic [31:0] live_val;
  logic        sel_change;
  logic        val_change;

  assign live_val   = bus.reg_state.xregs[bus.sel];
  assign sel_change = !bus.freeze && (bus.sel != snap_idx_q);
  assign val_change = !bus.freeze && (bus.sel == snap_idx_q) && (live_val != snap_q);

  // A select change restarts paging and takes priority over the terminal count
  always_comb begin
    snap_d     = snap_q;
    snap_idx_d = snap_idx_q;
    page_d     = page_q;
    timer_d    = timer_q;
    stretch_d  = stretch_q;
    if (!bus.freeze) begin
      snap_d     = live_val;
      snap_idx_d = bus.sel;
    end
    if (sel_change) begin
      page_d  = PAGE_LO;
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      page_d  = (page_q == PAGE_LO) ? PAGE_HI : PAGE_LO;
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    if (val_change) begin
      stretch_d = STRETCH_LOAD;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end
    changed_d = (stretch_d != '0);
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nibble[i] = snap_q[4*i +: 4];
    end
    if (page_q == PAGE_HI) begin
      nibble[5] = {3'b000, snap_idx_q[4]};
      nibble[4] = snap_idx_q[3:0];
      nibble[1] = snap_q[31:28];
      nibble[0] = snap_q[27:24];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_hex u_dec (
      .nibble (nibble[g]),
      .seg    (seg[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[i] = seg[i];
    end
    if (page_q == PAGE_HI) begin
      hex_d[3] = SEG_BLANK;
      hex_d[2] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q     <= '0;
      snap_idx_q <= '0;
      page_q     <= PAGE_LO;
      timer_q    <= '0;
      stretch_q  <= '0;
      changed_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_q[i] <= SEG_BLANK;
      end
    end else begin
      snap_q     <= snap_d;
      snap_idx_q <= snap_idx_d;
      page_q     <= page_d;
      timer_q    <= timer_d;
      stretch_q  <= stretch_d;
      changed_q  <= changed_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign bus.hex0    = hex_q[0];
  assign bus.hex1    = hex_q[1];
  assign bus.hex2    = hex_q[2];
  assign bus.hex3    = hex_q[3];
  assign bus.hex4    = hex_q[4];
  assign bus.hex5    = hex_q[5];
  assign bus.changed = changed_q;
  assign bus.page    = page_q;

endmodule

// File: tb/tb_reg_viewer.sv
// Self-checking bench for reg_viewer: cycle-level reference model plus
// directed scenarios and a randomized soak.
module tb_reg_viewer;

  localparam int P = 8;
  localparam int S = 4;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk;
  logic reset;
  logic cmp_en;
  int   checks;
  int   errors;

  reg_viewer_if bus ();

  reg_viewer #(.PAGE_CYCLES(P), .STRETCH_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_out(input int i);
    case (i)
      0: return bus.hex0;
      1: return bus.hex1;
      2: return bus.hex2;
      3: return bus.hex3;
      4: return bus.hex4;
      default: return bus.hex5;
    endcase
  endfunction

  // Reference model: page phase and change stretch derived from absolute cycle
  // numbers of the last select change and last value-change trigger.
  logic [31:0] m_snap;
  logic [4:0]  m_idx;
  logic [31:0] m_live;
  logic        m_sel_chg, m_val_chg;
  int          m_cycle, m_start, m_trig;
  logic [6:0]  exp_hex [6];
  logic        exp_changed, exp_page;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_snap = '0; m_idx = '0;
      m_cycle = 0; m_start = 0; m_trig = -1000;
      for (int i = 0; i < 6; i++) exp_hex[i] = BLANK;
      exp_changed = 1'b0;
      exp_page    = 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) exp_hex[i] = SEG_REF[m_snap[4*i +: 4]];
      if (exp_page) begin
        exp_hex[5] = SEG_REF[{3'b000, m_idx[4]}];
        exp_hex[4] = SEG_REF[m_idx[3:0]];
        exp_hex[3] = BLANK;
        exp_hex[2] = BLANK;
        exp_hex[1] = SEG_REF[m_snap[31:28]];
        exp_hex[0] = SEG_REF[m_snap[27:24]];
      end
      m_live    = bus.reg_state.xregs[bus.sel];
      m_sel_chg = !bus.freeze && (bus.sel != m_idx);
      m_val_chg = !bus.freeze && (bus.sel == m_idx) && (m_live != m_snap);
      m_cycle++;
      if (m_sel_chg) m_start = m_cycle;
      if (m_val_chg) m_trig = m_cycle;
      if (!bus.freeze) begin
        m_snap = m_live;
        m_idx  = bus.sel;
      end
      exp_page    = (((m_cycle - m_start) / P) % 2) == 1;
      exp_changed = (m_cycle - m_trig) < S;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 6; i++) check_output($sformatf("model_hex%0d", i), hex_out(i), exp_hex[i]);
      check_output("model_changed", bus.changed, exp_changed);
      check_output("model_page", bus.page, exp_page);
    end
  end

  task automatic wait_page(input logic val, input string name, output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.page === val) break;
    end
    check_output(name, bus.page, val);
  endtask

  task automatic count_changed(input logic [31:0] retrig_val, input bit do_retrig, output int n);
    bit done_retrig;
    done_retrig = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.changed === 1'b1) n++;
      else if (n > 0) break;
      if (do_retrig && n == 2 && !done_retrig) begin
        bus.reg_state.xregs[bus.sel] = retrig_val;
        done_retrig = 1'b1;
      end
    end
  endtask

  task automatic check_all_reset(input string tag);
    for (int i = 0; i < 6; i++) check_output($sformatf("%s_hex%0d", tag, i), hex_out(i), BLANK);
    check_output({tag, "_changed"}, bus.changed, 1'b0);
    check_output({tag, "_page"}, bus.page, 1'b0);
  endtask

  task automatic apply_stimulus(input int cycles);
    int r;
    int pool [4];
    pool = '{0, 3, 10, 31};
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 8) bus.sel = 5'(pool[$urandom_range(0, 3)]);
      else if (r < 11) bus.sel = 5'($urandom_range(0, 31));
      else if (r < 16) bus.freeze = ~bus.freeze;
      else if (r < 40) bus.reg_state.xregs[bus.sel] = $urandom;
      else if (r < 50) bus.reg_state.xregs[$urandom_range(0, 31)] = $urandom;
    end
  endtask

  initial begin
    int n;
    logic [6:0] lo_exp [6];
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    reset  = 1'b0;
    bus.freeze = 1'b0;
    bus.sel    = 5'd10;
    for (int i = 0; i < 32; i++) bus.reg_state.xregs[i] = $urandom;
    bus.reg_state.xregs[10] = 32'h12AB_CDEF;
    bus.reg_state.xregs[31] = 32'h9876_5432;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1 check_all_reset("reset_async");
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First display two edges after release: A b C d E F
    lo_exp = '{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) check_output($sformatf("first_hex%0d", i), hex_out(i), lo_exp[i]);

    // Low page lasts 8 cycles from the sampling edge, then the high page shows 0A -- 12
    wait_page(1'b1, "page_to_hi", n);
    check_output("lo_page_len", n + 2, 9);
    @(negedge clk);
    check_output("hi_hex5", bus.hex5, 7'b1000000);
    check_output("hi_hex4", bus.hex4, 7'b0001000);
    check_output("hi_hex3", bus.hex3, BLANK);
    check_output("hi_hex2", bus.hex2, BLANK);
    check_output("hi_hex1", bus.hex1, 7'b1111001);
    check_output("hi_hex0", bus.hex0, 7'b0100100);
    wait_page(1'b0, "page_to_lo", n);
    check_output("hi_page_len", n + 1, 8);

    // Change stretch, then retrigger two cycles in
    bus.reg_state.xregs[10] = 32'h12AB_CDF0;
    count_changed(32'h0, 1'b0, n);
    check_output("stretch_len", n, 4);
    bus.reg_state.xregs[10] = 32'h12AB_CDF1;
    count_changed(32'h12AB_CE00, 1'b1, n);
    check_output("retrigger_len", n, 6);

    // Select change during the high page
    wait_page(1'b1, "page_hi_before_sel", n);
    bus.sel = 5'd31;
    @(negedge clk);
    check_output("sel_page_lo", bus.page, 1'b0);
    check_output("sel_no_changed", bus.changed, 1'b0);
    wait_page(1'b1, "sel_page_hi", n);
    check_output("sel_page_len", n, 8);
    @(negedge clk);
    check_output("sel_hex5", bus.hex5, 7'b1111001);
    check_output("sel_hex4", bus.hex4, 7'b0001110);
    check_output("sel_changed", bus.changed, 1'b0);

    // Freeze holds snapshot and ignores sel, release pulses changed
    bus.freeze = 1'b1;
    bus.reg_state.xregs[31] = 32'hFEDC_BA98;
    bus.sel = 5'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("frozen_changed", bus.changed, 1'b0);
    end
    bus.sel = 5'd31;
    bus.freeze = 1'b0;
    count_changed(32'h0, 1'b0, n);
    check_output("unfreeze_stretch_len", n, 4);

    // Reset in the high page while changed is active
    wait_page(1'b1, "page_hi_before_reset", n);
    bus.reg_state.xregs[31] = 32'h0000_0001;
    @(negedge clk);
    check_output("pre_reset_changed", bus.changed, 1'b1);
    check_output("pre_reset_page", bus.page, 1'b1);
    #2 reset = 1'b1;
    #1 check_all_reset("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_page(1'b1, "post_reset_page_hi", n);
    check_output("post_reset_page_len", n, 9);

    apply_stimulus(600);

    cmp_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
